// File: rtl/gray_updown_counter_if.sv
// Control/status bundle for the Gray up/down counter.
// The master drives the count controls; the slave returns the registered count and flags.
interface gray_updown_counter_if #(
    parameter int N = 4
);
    logic         en;
    logic         up_dn;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] out;
    logic [N-1:0] bin_out;
    logic         tc;
    logic         sat;

    modport master (
        output en, up_dn, load, load_val,
        input  out, bin_out, tc, sat
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output out, bin_out, tc, sat
    );
endinterface

// File: rtl/gray_updown_counter.sv
// N-bit up/down counter held in binary, presented as registered Gray and binary
// with terminal-count and saturation flags; wraps or saturates per SATURATE.
module gray_updown_counter #(
    parameter int N        = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    gray_updown_counter_if.slave    bus
);
    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] MAX  = '1;
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] bin_q,  bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         tc_q,   tc_d;
    logic         sat_q,  sat_d;

    logic         at_max, at_min;
    logic         blocked;
    logic [N-1:0] load_bin;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign at_max   = (bin_q == MAX);
    assign at_min   = (bin_q == ZERO);
    assign load_bin = gray2bin(bus.load_val);

    // A step is blocked only in saturate mode when it would leave the range.
    assign blocked  = SATURATE && bus.en &&
                      ((bus.up_dn && at_max) || (!bus.up_dn && at_min));

    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        sat_d = 1'b0;
        if (bus.load) begin
            bin_d = load_bin;
        end else if (bus.en) begin
            if (blocked) begin
                sat_d = 1'b1;
            end else if (bus.up_dn) begin
                bin_d = bin_q + ONE;
                tc_d  = SATURATE ? (bin_q == MAX - ONE) : at_max;
            end else begin
                bin_d = bin_q - ONE;
                tc_d  = SATURATE ? (bin_q == ONE) : at_min;
            end
        end
    end

    // Gray is registered from the next binary value so both outputs change together.
    assign gray_d = bin_d ^ (bin_d >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
            sat_q  <= sat_d;
        end
    end

    assign bus.out     = gray_q;
    assign bus.bin_out = bin_q;
    assign bus.tc      = tc_q;
    assign bus.sat     = sat_q;
endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed table-driven bench for gray_updown_counter: one wrap-mode and one
// saturate-mode instance, plus async-reset and random-walk scoreboard sequences.
module tb_gray_updown_counter;
    typedef struct {
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [3:0] eo;
        logic [3:0] eb;
        logic       etc;
        logic       esat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    vec_t wv[$];
    vec_t sv[$];

    gray_updown_counter_if #(.N(4)) wif ();
    gray_updown_counter_if #(.N(4)) sif ();

    gray_updown_counter #(.N(4), .SATURATE(1'b0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wif.slave)
    );

    gray_updown_counter #(.N(4), .SATURATE(1'b1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic ld, logic [3:0] lv, logic en, logic up,
                                logic [3:0] eo, logic [3:0] eb, logic etc, logic esat);
        vec_t v;
        v.load = ld; v.lv = lv; v.en = en; v.up = up;
        v.eo = eo; v.eb = eb; v.etc = etc; v.esat = esat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        wif.en = 1'b0; wif.up_dn = 1'b0; wif.load = 1'b0; wif.load_val = 4'b0000;
        sif.en = 1'b0; sif.up_dn = 1'b0; sif.load = 1'b0; sif.load_val = 4'b0000;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".w.out"}, {28'd0, wif.out}, 32'd0);
        chk({tag, ".w.bin"}, {28'd0, wif.bin_out}, 32'd0);
        chk({tag, ".w.tc"}, {31'd0, wif.tc}, 32'd0);
        chk({tag, ".w.sat"}, {31'd0, wif.sat}, 32'd0);
        chk({tag, ".s.out"}, {28'd0, sif.out}, 32'd0);
        chk({tag, ".s.bin"}, {28'd0, sif.bin_out}, 32'd0);
        chk({tag, ".s.tc"}, {31'd0, sif.tc}, 32'd0);
        chk({tag, ".s.sat"}, {31'd0, sif.sat}, 32'd0);
    endtask

    task automatic run_vec(input bit use_sat, input int idx, input vec_t v);
        string tag;
        tag = $sformatf("%s[%0d]", use_sat ? "sat" : "wrap", idx);
        if (use_sat) begin
            sif.load = v.load; sif.load_val = v.lv; sif.en = v.en; sif.up_dn = v.up;
        end else begin
            wif.load = v.load; wif.load_val = v.lv; wif.en = v.en; wif.up_dn = v.up;
        end
        @(posedge clk);
        #1;
        if (use_sat) begin
            chk({tag, ".out"}, {28'd0, sif.out}, {28'd0, v.eo});
            chk({tag, ".bin"}, {28'd0, sif.bin_out}, {28'd0, v.eb});
            chk({tag, ".tc"}, {31'd0, sif.tc}, {31'd0, v.etc});
            chk({tag, ".sat"}, {31'd0, sif.sat}, {31'd0, v.esat});
        end else begin
            chk({tag, ".out"}, {28'd0, wif.out}, {28'd0, v.eo});
            chk({tag, ".bin"}, {28'd0, wif.bin_out}, {28'd0, v.eb});
            chk({tag, ".tc"}, {31'd0, wif.tc}, {31'd0, v.etc});
            chk({tag, ".sat"}, {31'd0, wif.sat}, {31'd0, v.esat});
        end
    endtask

    initial begin
        logic [3:0] mb;
        logic [3:0] prev_out;
        logic       r_en, r_up, exp_tc;

        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        idle_all();

        // Wrap mode from reset: 17 up steps through the wrap, hold, down through wrap,
        // load with en ignored, load clearing tc, immediate direction change.
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0001,  1, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0011,  2, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0010,  3, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0110,  4, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0111,  5, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0101,  6, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0100,  7, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b1100,  8, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b1101,  9, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b1111, 10, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b1110, 11, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b1010, 12, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b1011, 13, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b1001, 14, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b1000, 15, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0000,  0, 1, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0001,  1, 0, 0));
        wv.push_back(mk(0, 4'b0000, 0, 1, 4'b0001,  1, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000,  0, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 0, 4'b1000, 15, 1, 0));
        wv.push_back(mk(0, 4'b0000, 1, 0, 4'b1001, 14, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 0, 4'b1011, 13, 0, 0));
        wv.push_back(mk(1, 4'b1101, 1, 0, 4'b1101,  9, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b1111, 10, 0, 0));
        wv.push_back(mk(1, 4'b0000, 1, 1, 4'b0000,  0, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 0, 4'b1000, 15, 1, 0));
        wv.push_back(mk(1, 4'b0000, 0, 0, 4'b0000,  0, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 1, 4'b0001,  1, 0, 0));
        wv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000,  0, 0, 0));
        wv.push_back(mk(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0));

        // Saturate mode: blocked steps at both limits, arrival tc, load clearing flags.
        sv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000,  0, 0, 1));
        sv.push_back(mk(1, 4'b1000, 1, 1, 4'b1000, 15, 0, 0));
        sv.push_back(mk(0, 4'b0000, 1, 1, 4'b1000, 15, 0, 1));
        sv.push_back(mk(0, 4'b0000, 1, 1, 4'b1000, 15, 0, 1));
        sv.push_back(mk(0, 4'b0000, 1, 1, 4'b1000, 15, 0, 1));
        sv.push_back(mk(0, 4'b0000, 1, 0, 4'b1001, 14, 0, 0));
        sv.push_back(mk(1, 4'b0001, 0, 0, 4'b0001,  1, 0, 0));
        sv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000,  0, 1, 0));
        sv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000,  0, 0, 1));
        sv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000,  0, 0, 0));
        sv.push_back(mk(0, 4'b0000, 1, 1, 4'b0001,  1, 0, 0));
        sv.push_back(mk(1, 4'b1001, 0, 0, 4'b1001, 14, 0, 0));
        sv.push_back(mk(0, 4'b0000, 1, 1, 4'b1000, 15, 1, 0));
        sv.push_back(mk(0, 4'b0000, 1, 1, 4'b1000, 15, 0, 1));
        sv.push_back(mk(0, 4'b0000, 0, 1, 4'b1000, 15, 0, 0));

        // Reset state before any clock edge, then inputs ignored while held in reset.
        #1;
        chk_zero("rst_async");
        wif.en = 1'b1; wif.up_dn = 1'b1; wif.load = 1'b1; wif.load_val = 4'b1111;
        sif.en = 1'b1; sif.up_dn = 1'b0; sif.load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_zero("rst_held");
        idle_all();
        rst = 1'b1;

        foreach (wv[i]) run_vec(1'b0, i, wv[i]);
        idle_all();
        foreach (sv[i]) run_vec(1'b1, i, sv[i]);
        idle_all();

        // Async reset mid-count: wrap at 0110, saturate instance holding sat=1,
        // a step and a load pending when reset drops between edges.
        wif.load = 1'b1; wif.load_val = 4'b0110;
        sif.en = 1'b1; sif.up_dn = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_pre.w.out", {28'd0, wif.out}, 32'h6);
        chk("arst_pre.w.bin", {28'd0, wif.bin_out}, 32'h4);
        chk("arst_pre.s.sat", {31'd0, sif.sat}, 32'h1);
        wif.load = 1'b0; wif.en = 1'b1; wif.up_dn = 1'b1;
        sif.en = 1'b0; sif.load = 1'b1; sif.load_val = 4'b0101;
        #2;
        rst = 1'b0;
        #1;
        chk_zero("arst_now");
        @(posedge clk);
        #1;
        chk_zero("arst_hold");
        idle_all();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("arst_rel");

        // Random walk on the wrap instance against a small binary model.
        mb = 4'd0;
        prev_out = wif.out;
        for (int c = 0; c < 1000; c++) begin
            r_en = 1'($urandom_range(0, 1));
            r_up = 1'($urandom_range(0, 1));
            wif.en = r_en; wif.up_dn = r_up;
            exp_tc = r_en && ((r_up && mb == 4'd15) || (!r_up && mb == 4'd0));
            if (r_en) mb = r_up ? mb + 4'd1 : mb - 4'd1;
            @(posedge clk);
            #1;
            chk($sformatf("rnd[%0d].bin", c), {28'd0, wif.bin_out}, {28'd0, mb});
            chk($sformatf("rnd[%0d].gray", c), {28'd0, wif.out}, {28'd0, mb ^ (mb >> 1)});
            chk($sformatf("rnd[%0d].tc", c), {31'd0, wif.tc}, {31'd0, exp_tc});
            chk($sformatf("rnd[%0d].ham", c), {31'd0, ($countones(wif.out ^ prev_out) <= 1)}, 32'd1);
            if (!r_en) chk($sformatf("rnd[%0d].hold", c), {28'd0, wif.out}, {28'd0, prev_out});
            prev_out = wif.out;
        end
        idle_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the counter width in bits; legal range is 2..16.
REQ-002 The block SHALL have parameter SATURATE, default 0: 0 selects wrap mode, 1 selects saturate mode.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up_dn, input, 1 bit: 1 counts up, 0 counts down.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 The block SHALL have port load_val, input, N bits: Gray-coded value to load.
REQ-009 The block SHALL have port out, output, N bits: registered Gray-coded count.
REQ-010 The block SHALL have port bin_out, output, N bits: registered binary equivalent of out.
REQ-011 The block SHALL have port tc, output, 1 bit: registered terminal-count/wrap pulse.
REQ-012 The block SHALL have port sat, output, 1 bit: registered saturation-hold flag; it is always 0 when SATURATE=0.

Function
REQ-013 The block SHALL hold the count internally as an N-bit binary value B.
- out = B ^ (B >> 1).
- bin_out = B.
- Both outputs update on the same clk edge as B, so there is no skew between them.
REQ-014 Operation priority per rising edge SHALL be: load > en > hold.
REQ-015 When load=1, B SHALL take the Gray-to-binary conversion of load_val.
- Conversion: B[N-1] = G[N-1]; B[i] = B[i+1] ^ G[i] for i going downward.
- The load takes effect one cycle later, and en/up_dn are ignored in that cycle.
REQ-016 When load=0 and en=1, B SHALL become B+1 if up_dn=1 and B-1 if up_dn=0, modulo 2^N (wrap mode).
REQ-017 When load=0 and en=0, B, out and bin_out SHALL hold.
REQ-018 In wrap mode, each enabled step SHALL change exactly one bit of out, including the wrap-around steps.
- Up wrap: Gray of 2^N-1 -> 0.
- Down wrap: 0 -> Gray of 2^N-1.
REQ-019 In wrap mode, tc SHALL be 1 for exactly the one cycle after an enabled step that wraps (2^N-1 -> 0 going up, 0 -> 2^N-1 going down), and 0 otherwise.
REQ-020 In saturate mode, an enabled up-step at B=2^N-1 or an enabled down-step at B=0 SHALL leave B unchanged.
REQ-021 In saturate mode, sat SHALL be 1 in the cycle after any blocked step as defined in REQ-020, and 0 after any other edge.
REQ-022 In saturate mode, tc SHALL be 1 for one cycle after an enabled step that arrives at the limit (2^N-2 -> 2^N-1 going up, 1 -> 0 going down).
REQ-023 A load SHALL clear tc and sat on the next edge, even when the loaded value equals a limit.
REQ-024 An up_dn change while en=1 SHALL take effect on the same edge, with no extra latency or dead cycle.
REQ-025 Latency from any input to any output SHALL be one clk cycle.

Reset
REQ-026 When rst=0, B, out, bin_out, tc and sat SHALL all go to 0 immediately, independent of clk.
REQ-027 While rst=0, all inputs SHALL be ignored.
REQ-028 The first count SHALL occur on the first rising clk edge on which rst=1 and en=1.
REQ-029 Reset asserted mid-count SHALL abort any pending load or step, and no tc or sat pulse SHALL appear after reset.

Verification
REQ-030 Free-run scenario, N=4, wrap mode: rst=0 for 10 cycles, then rst=1, en=1, up_dn=1 for 20 cycles.
- Required out sequence: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000,0001,0011,0010.
- Required tc=1 only in the cycle where out returns to 0000.
REQ-031 Down-count scenario, wrap mode: from reset, en=1, up_dn=0 for 3 cycles.
- Required out: 1000, 1001, 1011.
- Required bin_out: 15, 14, 13.
- Required tc=1 in the first cycle only.
REQ-032 Load scenario: load=1 with load_val=1101 and en=1 in the same cycle.
- Required next cycle: out=1101, bin_out=9, tc=0, with no count applied.
- Next enabled up-step: out=1111, bin_out=10.
REQ-033 Saturate scenario, SATURATE=1: load 1000 (bin 15), then en=1, up_dn=1 for 3 cycles.
- Required: out stays 1000; sat=1 on each of those cycles; tc=0.
- Then up_dn=0: out=1001, bin_out=14, sat=0.
REQ-034 Asynchronous reset scenario: drop rst to 0 between clk edges while out=0110.
- Required: out, bin_out, tc and sat read 0 before the next clk edge.
REQ-035 Hold and Gray-property scenario: random en/up_dn stimulus for 1000 cycles with a scoreboard.
- Required: the Hamming distance between consecutive out values is <=1.
- Required: out equals Gray(bin_out) on every cycle.
- Required: out is unchanged on every cycle where en=0.
